// File: rtl/ram_bist.sv
// March-test initiator for a single-port read-first synchronous RAM (16x8 by default).
// Define BIST_ABORT_ON_FAIL_EN to end the run on the first registered mismatch.
module ram_bist #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W-1:0] fail_data,
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_din,
   input  logic [DATA_W-1:0] ram_dout
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_M0    = 3'd1;
   localparam logic [2:0] S_M1    = 3'd2;
   localparam logic [2:0] S_M2    = 3'd3;
   localparam logic [2:0] S_M3    = 3'd4;
   localparam logic [2:0] S_DRAIN = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;

   localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
   localparam logic [DATA_W-1:0] ONES      = {DATA_W{1'b1}};

   logic [2:0]        state_q, state_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              pass_q, pass_d;
   logic              fail_seen_q, fail_seen_d;
   logic [ADDR_W-1:0] fail_addr_q, fail_addr_d;
   logic [DATA_W-1:0] fail_data_q, fail_data_d;
   logic              ram_we_q, ram_we_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [DATA_W-1:0] ram_din_q, ram_din_d;
   logic              chk1_vld_q, chk1_vld_d;
   logic [DATA_W-1:0] chk1_exp_q, chk1_exp_d;
   logic [ADDR_W-1:0] chk1_addr_q, chk1_addr_d;
   logic              chk2_vld_q, chk2_vld_d;
   logic [DATA_W-1:0] chk2_exp_q, chk2_exp_d;
   logic [ADDR_W-1:0] chk2_addr_q, chk2_addr_d;
   logic [ADDR_W-1:0] naddr;
   logic              issue;
   logic              mismatch;

   always_comb begin
      state_d     = state_q;
      busy_d      = busy_q;
      done_d      = done_q;
      pass_d      = pass_q;
      fail_seen_d = fail_seen_q;
      fail_addr_d = fail_addr_q;
      fail_data_d = fail_data_q;
      ram_we_d    = 1'b0;
      ram_addr_d  = '0;
      ram_din_d   = '0;
      chk1_vld_d  = 1'b0;
      chk1_exp_d  = '0;
      chk1_addr_d = '0;
      chk2_vld_d  = chk1_vld_q;
      chk2_exp_d  = chk1_exp_q;
      chk2_addr_d = chk1_addr_q;
      naddr       = '0;
      issue       = 1'b0;

      // Stage 2 holds the op whose read data is on ram_dout this cycle.
      mismatch = busy_q && chk2_vld_q && (ram_dout != chk2_exp_q);
      if (mismatch && !fail_seen_q) begin
         fail_seen_d = 1'b1;
         fail_addr_d = chk2_addr_q;
         fail_data_d = ram_dout;
      end

      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               state_d     = S_M0;
               busy_d      = 1'b1;
               done_d      = 1'b0;
               pass_d      = 1'b0;
               fail_seen_d = 1'b0;
               fail_addr_d = '0;
               fail_data_d = '0;
               issue       = 1'b1;
            end
         end
         S_M0: begin
            issue = 1'b1;
            if (ram_addr_q == ADDR_LAST) state_d = S_M1;
            else                         naddr   = ram_addr_q + 1'b1;
         end
         S_M1: begin
            issue = 1'b1;
            if (ram_addr_q == ADDR_LAST) begin
               state_d = S_M2;
               naddr   = ADDR_LAST;
            end else begin
               naddr = ram_addr_q + 1'b1;
            end
         end
         S_M2: begin
            issue = 1'b1;
            if (ram_addr_q == '0) state_d = S_M3;
            else                  naddr   = ram_addr_q - 1'b1;
         end
         S_M3: begin
            if (ram_addr_q == ADDR_LAST) begin
               state_d = S_DRAIN;
            end else begin
               issue = 1'b1;
               naddr = ram_addr_q + 1'b1;
            end
         end
         S_DRAIN: begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = !(fail_seen_q || mismatch);
         end
         default: state_d = S_IDLE;
      endcase

`ifdef BIST_ABORT_ON_FAIL_EN
      if (mismatch) begin
         state_d = S_DONE;
         busy_d  = 1'b0;
         done_d  = 1'b1;
         pass_d  = 1'b0;
         issue   = 1'b0;
      end
`endif

      // Op fields and expected read are derived from the state being entered.
      if (issue) begin
         ram_we_d    = (state_d != S_M3);
         ram_addr_d  = naddr;
         ram_din_d   = (state_d == S_M1) ? ONES : '0;
         chk1_vld_d  = (state_d != S_M0);
         chk1_exp_d  = (state_d == S_M2) ? ONES : '0;
         chk1_addr_d = naddr;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         fail_seen_q <= 1'b0;
         fail_addr_q <= '0;
         fail_data_q <= '0;
         ram_we_q    <= 1'b0;
         ram_addr_q  <= '0;
         ram_din_q   <= '0;
         chk1_vld_q  <= 1'b0;
         chk1_exp_q  <= '0;
         chk1_addr_q <= '0;
         chk2_vld_q  <= 1'b0;
         chk2_exp_q  <= '0;
         chk2_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         pass_q      <= pass_d;
         fail_seen_q <= fail_seen_d;
         fail_addr_q <= fail_addr_d;
         fail_data_q <= fail_data_d;
         ram_we_q    <= ram_we_d;
         ram_addr_q  <= ram_addr_d;
         ram_din_q   <= ram_din_d;
         chk1_vld_q  <= chk1_vld_d;
         chk1_exp_q  <= chk1_exp_d;
         chk1_addr_q <= chk1_addr_d;
         chk2_vld_q  <= chk2_vld_d;
         chk2_exp_q  <= chk2_exp_d;
         chk2_addr_q <= chk2_addr_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_addr = fail_addr_q;
   assign fail_data = fail_data_q;
   assign ram_we    = ram_we_q;
   assign ram_addr  = ram_addr_q;
   assign ram_din   = ram_din_q;

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: read-first RAM model with injectable stuck-at bits,
// and an array-level march model that predicts each run's result.
module tb_ram_bist;

   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic          busy, done, pass, ram_we;
   logic [AW-1:0] fail_addr, ram_addr;
   logic [DW-1:0] fail_data, ram_din, ram_dout;

   logic [DW-1:0] mem [DEPTH];
   logic [DW-1:0] s0 [DEPTH];
   logic [DW-1:0] s1 [DEPTH];
   logic          scramble = 1'b0;

   int n_assert = 0;
   int n_fail   = 0;

   ram_bist #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .pass(pass), .fail_addr(fail_addr), .fail_data(fail_data),
      .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
   );

   always #5 clk = ~clk;

   // Read-first RAM; stuck bits are forced on every write.
   always @(posedge clk) begin
      if (scramble) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= DW'($urandom);
      end else begin
         ram_dout <= mem[ram_addr];
         if (ram_we) mem[ram_addr] <= (ram_din & ~s0[ram_addr]) | s1[ram_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic clear_faults();
      for (int i = 0; i < DEPTH; i++) begin
         s0[i] = '0;
         s1[i] = '0;
      end
   endtask

   task automatic chk_all_zero(input string when);
      chk({when, "_busy"}, busy, 0);
      chk({when, "_done"}, done, 0);
      chk({when, "_pass"}, pass, 0);
      chk({when, "_fail_addr"}, fail_addr, 0);
      chk({when, "_fail_data"}, fail_data, 0);
      chk({when, "_ram_we"}, ram_we, 0);
      chk({when, "_ram_addr"}, ram_addr, 0);
      chk({when, "_ram_din"}, ram_din, 0);
   endtask

   // March on a plain array: each element visits its addresses, reads then writes.
   task automatic model(output bit ep, output logic [AW-1:0] fa, output logic [DW-1:0] fd,
                        output int edone);
      logic [DW-1:0] m [DEPTH];
      bit            failed;
      int            fk, a;
      logic [DW-1:0] expv, wr;
      failed = 0; fk = 0; fa = '0; fd = '0;
      for (int i = 0; i < DEPTH; i++) m[i] = s1[i];
      for (int e = 1; e <= 3; e++) begin
         for (int i = 0; i < DEPTH; i++) begin
            a    = (e == 2) ? DEPTH - 1 - i : i;
            expv = (e == 2) ? 8'hFF : 8'h00;
            if (!failed && m[a] != expv) begin
               failed = 1; fk = 16 * e + i; fa = AW'(a); fd = m[a];
            end
            wr = (e == 1) ? 8'hFF : 8'h00;
            if (e < 3) m[a] = (wr & ~s0[a]) | s1[a];
         end
      end
      ep    = !failed;
      edone = 65;
`ifdef BIST_ABORT_ON_FAIL_EN
      if (failed) edone = fk + 2;
`endif
   endtask

   // Launches start one edge later; returns with time at #1 after the start edge (E0).
   task automatic launch();
      repeat ($urandom_range(0, 3)) begin
         @(posedge clk); #1;
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run(input int rp1, input int rp2, input bit chk_seq);
      bit            ep;
      logic [AW-1:0] efa;
      logic [DW-1:0] efd;
      int            edone, c, busy_bad, e, i;
      model(ep, efa, efd, edone);
      launch();
      c = 0;
      busy_bad = 0;
      while (!done && c < 200) begin
         if (busy !== 1'b1) busy_bad++;
         if (chk_seq && c < 64 && c < edone) begin
            e = c / 16;
            i = c % 16;
            chk($sformatf("op%0d_we", c), ram_we, (e < 3) ? 1 : 0);
            chk($sformatf("op%0d_addr", c), ram_addr, (e == 2) ? 15 - i : i);
            chk($sformatf("op%0d_din", c), ram_din, (e == 1) ? 8'hFF : 8'h00);
         end
         start = (c + 1 == rp1 || c + 1 == rp2);
         @(posedge clk); #1;
         c++;
      end
      start = 1'b0;
      chk("done_edge", c, edone);
      chk("busy_during_run", busy_bad, 0);
      chk("busy_at_done", busy, 0);
      chk("pass", pass, ep);
      chk("fail_addr", fail_addr, efa);
      chk("fail_data", fail_data, efd);
      chk("we_at_done", ram_we, 0);
      repeat (3) @(posedge clk);
      #1;
      chk("done_held", done, 1);
      chk("pass_held", pass, ep);
      chk("we_idle", ram_we, 0);
   endtask

   initial begin
      int fa, fb;
      clear_faults();
      #2 rst_n = 1'b0;
      #1 chk_all_zero("reset");
      scramble = 1'b1;
      @(posedge clk); #1;
      scramble = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Fault-free run with full sequence monitor.
      run(-1, -1, 1'b1);

      // start re-pulsed mid-run must be ignored.
      run(20, 40, 1'b0);

      // mem[9] bit 3 stuck-at-0: first caught in M2 at k=38.
      s0[9] = 8'h08;
      run(-1, -1, 1'b1);
      clear_faults();

      // Reset at E30 for two cycles, then a full clean rerun.
      launch();
      repeat (30) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1 chk_all_zero("midrun_reset");
      @(posedge clk);
      @(posedge clk); #1;
      chk_all_zero("reset_held");
      rst_n = 1'b1;
      run(-1, -1, 1'b0);

      // Random single stuck-at faults.
      for (int t = 0; t < 4; t++) begin
         clear_faults();
         fa = $urandom_range(0, DEPTH - 1);
         fb = $urandom_range(0, DW - 1);
         if ($urandom_range(0, 1) == 1) s1[fa] = DW'(1 << fb);
         else                           s0[fa] = DW'(1 << fb);
         run(-1, -1, 1'b0);
      end

      // Two faults: only the first along the march order is reported.
      clear_faults();
      s0[3]  = 8'h40;
      s1[12] = 8'h01;
      run(-1, -1, 1'b0);
      clear_faults();
      run(-1, -1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
